// File: rtl/fetch_prefetch_queue.sv
// In-order prefetch FIFO between instruction fetch and decode; blocks further fetches after a faulted word until flush.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue with a ready decoder forwards the fetch word combinationally.
module fetch_prefetch_queue #(
  parameter int DEPTH      = 4,
  parameter int RISCV_ARCH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_f_valid,
  input  logic [RISCV_ARCH-1:0]   i_f_pc,
  input  logic [63:0]             i_f_instr,
  input  logic                    i_f_load_fault,
  input  logic                    i_f_page_fault_x,
  output logic                    o_f_ready,
  output logic                    o_d_valid,
  output logic [RISCV_ARCH-1:0]   o_d_pc,
  output logic [63:0]             o_d_instr,
  output logic                    o_d_load_fault,
  output logic                    o_d_page_fault_x,
  input  logic                    i_d_ready,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty,
  output logic                    o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [RISCV_ARCH-1:0] pc;
    logic [63:0]           instr;
    logic                  load_fault;
    logic                  page_fault_x;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fault_lock_q, fault_lock_d;

  entry_t          in_entry;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            bypass;
  logic            f_fault;

  always_comb begin
    in_entry  = '{pc: i_f_pc, instr: i_f_instr,
                  load_fault: i_f_load_fault, page_fault_x: i_f_page_fault_x};
    f_fault   = i_f_load_fault | i_f_page_fault_x;
    o_full    = (count_q == CW'(DEPTH));
    o_empty   = (count_q == '0);
    o_count   = count_q;
    // Ready depends only on registered state, never on the decoder handshake.
    o_f_ready = ~o_full & ~fault_lock_q;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass    = o_empty & i_f_valid & i_d_ready & ~i_flush & ~fault_lock_q;
`else
    bypass    = 1'b0;
`endif
    head      = bypass ? in_entry : mem_q[rptr_q];
    o_d_valid = (~o_empty & ~i_flush) | bypass;
    o_d_pc           = head.pc;
    o_d_instr        = head.instr;
    o_d_load_fault   = head.load_fault;
    o_d_page_fault_x = head.page_fault_x;

    push = i_f_valid & o_f_ready & ~i_flush & ~bypass;
    pop  = ~o_empty & ~i_flush & i_d_ready;

    mem_d = mem_q;
    if (push) mem_d[wptr_q] = in_entry;

    wptr_d       = wptr_q + AW'(push);
    rptr_d       = rptr_q + AW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
    fault_lock_d = fault_lock_q | ((push | bypass) & f_fault);

    // Flush rewinds the pointers but leaves stale entry contents in place.
    if (i_flush) begin
      wptr_d       = '0;
      rptr_d       = '0;
      count_d      = '0;
      fault_lock_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      fault_lock_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      fault_lock_q <= fault_lock_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model. Honours FETCH_QUEUE_BYPASS_EN if defined.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, f_valid, f_lf, f_pf, d_ready;
  logic [63:0] f_pc, f_instr;
  logic        o_f_ready, o_d_valid, o_d_lf, o_d_pf, o_empty, o_full;
  logic [63:0] o_d_pc, o_d_instr;
  logic [2:0]  o_count;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RISCV_ARCH(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_f_valid(f_valid), .i_f_pc(f_pc), .i_f_instr(f_instr),
    .i_f_load_fault(f_lf), .i_f_page_fault_x(f_pf),
    .o_f_ready(o_f_ready), .o_d_valid(o_d_valid), .o_d_pc(o_d_pc),
    .o_d_instr(o_d_instr), .o_d_load_fault(o_d_lf), .o_d_page_fault_x(o_d_pf),
    .i_d_ready(d_ready), .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] instr_of(input logic [63:0] pc);
    return {pc[31:0] ^ 32'hA5A5_0000, ~pc[31:0]};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        flush, valid;
    logic [63:0] pc;
    logic        pf, dr;
    logic        ev;
    logic [63:0] epc;
    int          ecnt;
    logic        erdy, epf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic fl, logic v, logic [63:0] pc, logic pf, logic dr,
                              logic ev, logic [63:0] epc, int ecnt, logic erdy, logic epf);
    vec_t t;
    t.flush = fl; t.valid = v; t.pc = pc; t.pf = pf; t.dr = dr;
    t.ev = ev; t.epc = epc; t.ecnt = ecnt; t.erdy = erdy; t.epf = epf;
    return t;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc, instr;
    logic        lf, pf;
  } ent_t;
  ent_t mq[$];
  bit   mlock;

  task automatic idle_inputs();
    flush = 0; f_valid = 0; f_pc = '0; f_instr = '0; f_lf = 0; f_pf = 0; d_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mq.delete();
    mlock = 0;
  endtask

  initial begin
    logic [63:0] next_pc, exp_rx, last_pc;
    int sent, got, bubbles;
    logic fault_seen;

    rst = 1'b1;
    idle_inputs();
    #12;
    // Reset state, checked while reset is still asserted
    chk("rst_f_ready", o_f_ready, 1);
    chk("rst_d_valid", o_d_valid, 0);
    chk("rst_empty",   o_empty,   1);
    chk("rst_full",    o_full,    0);
    chk("rst_count",   o_count,   0);
    chk("rst_d_pc",    o_d_pc,    0);
    chk("rst_d_instr", o_d_instr, 0);
    chk("rst_d_lf",    o_d_lf,    0);
    chk("rst_d_pf",    o_d_pf,    0);
    rst = 1'b0;

    // Expected outputs are those seen in the same cycle, before the clock edge.
    // fill 3, drain in order
    tbl.push_back(mk(0,0,64'h0,   0,0, 0,64'h0,   0,1,0));
    tbl.push_back(mk(0,1,64'h1000,0,0, 0,64'h0,   0,1,0));
    tbl.push_back(mk(0,1,64'h1004,0,0, 1,64'h1000,1,1,0));
    tbl.push_back(mk(0,1,64'h1008,0,0, 1,64'h1000,2,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,0, 1,64'h1000,3,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h1000,3,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h1004,2,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h1008,1,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,0, 0,64'h0,   0,1,0));
    // fill to full, 5th held, one pop re-opens
    tbl.push_back(mk(0,1,64'h1100,0,0, 0,64'h0,   0,1,0));
    tbl.push_back(mk(0,1,64'h1104,0,0, 1,64'h1100,1,1,0));
    tbl.push_back(mk(0,1,64'h1108,0,0, 1,64'h1100,2,1,0));
    tbl.push_back(mk(0,1,64'h110C,0,0, 1,64'h1100,3,1,0));
    tbl.push_back(mk(0,1,64'h1110,0,0, 1,64'h1100,4,0,0));
    tbl.push_back(mk(0,1,64'h1110,0,1, 1,64'h1100,4,0,0));
    tbl.push_back(mk(0,1,64'h1110,0,0, 1,64'h1104,3,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,0, 1,64'h1104,4,0,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h1104,4,0,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h1108,3,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h110C,2,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h1110,1,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,0, 0,64'h0,   0,1,0));
    // flush with 3 entries plus a concurrent fetch
    tbl.push_back(mk(0,1,64'h4100,0,0, 0,64'h0,   0,1,0));
    tbl.push_back(mk(0,1,64'h4104,0,0, 1,64'h4100,1,1,0));
    tbl.push_back(mk(0,1,64'h4108,0,0, 1,64'h4100,2,1,0));
    tbl.push_back(mk(1,1,64'h4000,0,1, 0,64'h0,   3,1,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 0,64'h0,   0,1,0));
    // faulted fetch locks the queue until flush
    tbl.push_back(mk(0,1,64'h3000,0,0, 0,64'h0,   0,1,0));
    tbl.push_back(mk(0,1,64'h3004,1,0, 1,64'h3000,1,1,0));
    tbl.push_back(mk(0,1,64'h3008,0,0, 1,64'h3000,2,0,0));
    tbl.push_back(mk(0,1,64'h3008,0,1, 1,64'h3000,2,0,0));
    tbl.push_back(mk(0,0,64'h0,   0,1, 1,64'h3004,1,0,1));
    tbl.push_back(mk(0,0,64'h0,   0,0, 0,64'h0,   0,0,0));
    tbl.push_back(mk(1,0,64'h0,   0,0, 0,64'h0,   0,0,0));
    tbl.push_back(mk(0,0,64'h0,   0,0, 0,64'h0,   0,1,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      flush = tbl[i].flush; f_valid = tbl[i].valid; f_pc = tbl[i].pc;
      f_instr = instr_of(tbl[i].pc); f_pf = tbl[i].pf; f_lf = 0; d_ready = tbl[i].dr;
      #1;
      chk($sformatf("tbl%0d_d_valid", i), o_d_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_count", i),   o_count,   tbl[i].ecnt);
      chk($sformatf("tbl%0d_f_ready", i), o_f_ready, tbl[i].erdy);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_d_pc", i),    o_d_pc,    tbl[i].epc);
        chk($sformatf("tbl%0d_d_instr", i), o_d_instr, instr_of(tbl[i].epc));
        chk($sformatf("tbl%0d_d_pf", i),    o_d_pf,    tbl[i].epf);
      end
    end

    // streaming 20 words with continuous valid/ready across pointer wrap
    next_pc = 64'h2000; exp_rx = 64'h2000; last_pc = '0;
    sent = 0; got = 0; bubbles = 0;
    for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
      @(negedge clk);
      flush = 0; f_lf = 0; f_pf = 0; d_ready = 1;
      f_valid = (sent < 20); f_pc = next_pc; f_instr = instr_of(next_pc);
      #1;
      if (o_d_valid) begin
        chk("stream_pc", o_d_pc, exp_rx);
        last_pc = o_d_pc;
        exp_rx += 4;
        got++;
      end else if (got > 0) bubbles++;
      if (f_valid && o_f_ready) begin
        sent++;
        next_pc += 4;
      end
    end
    chk("stream_words", got, 20);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_last_pc", last_pc, 64'h204C);
    @(negedge clk); idle_inputs(); #1;
    chk("stream_empty", o_empty, 1);

    // empty queue, ready decoder, single fetch
    @(negedge clk);
    f_valid = 1; f_pc = 64'h5000; f_instr = instr_of(64'h5000); d_ready = 1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid_same", o_d_valid, 1);
    chk("byp_pc_same", o_d_pc, 64'h5000);
    @(negedge clk); f_valid = 0; #1;
    chk("byp_count", o_count, 0);
    chk("byp_valid_next", o_d_valid, 0);
`else
    chk("nobyp_valid_same", o_d_valid, 0);
    @(negedge clk); f_valid = 0; #1;
    chk("nobyp_valid_next", o_d_valid, 1);
    chk("nobyp_pc_next", o_d_pc, 64'h5000);
    chk("nobyp_count", o_count, 1);
`endif
    @(negedge clk); idle_inputs(); #1;
    chk("byp_drained", o_empty, 1);

    // randomized run against the queue model
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic exp_rdy, exp_byp, exp_v;
      ent_t hd;
      @(negedge clk);
      flush   = ($urandom_range(0, 15) == 0);
      f_valid = ($urandom_range(0, 3) != 0);
      f_pc    = {32'h0, $urandom} & ~64'h3;
      f_instr = {$urandom, $urandom};
      f_lf    = ($urandom_range(0, 19) == 0);
      f_pf    = ($urandom_range(0, 19) == 0);
      d_ready = $urandom_range(0, 1);
      #1;
      exp_rdy = (mq.size() < DEPTH) && !mlock;
`ifdef FETCH_QUEUE_BYPASS_EN
      exp_byp = (mq.size() == 0) && f_valid && d_ready && !flush && !mlock;
`else
      exp_byp = 1'b0;
`endif
      exp_v = ((mq.size() > 0) && !flush) || exp_byp;
      chk("rnd_count",   o_count,   mq.size());
      chk("rnd_empty",   o_empty,   mq.size() == 0);
      chk("rnd_full",    o_full,    mq.size() == DEPTH);
      chk("rnd_f_ready", o_f_ready, exp_rdy);
      chk("rnd_d_valid", o_d_valid, exp_v);
      if (exp_v) begin
        if (exp_byp) hd = '{pc: f_pc, instr: f_instr, lf: f_lf, pf: f_pf};
        else         hd = mq[0];
        chk("rnd_d_pc",    o_d_pc,    hd.pc);
        chk("rnd_d_instr", o_d_instr, hd.instr);
        chk("rnd_d_lf",    o_d_lf,    hd.lf);
        chk("rnd_d_pf",    o_d_pf,    hd.pf);
      end
      if (flush) begin
        mq.delete();
        mlock = 0;
      end else begin
        fault_seen = 0;
        if (mq.size() > 0 && d_ready) void'(mq.pop_front());
        if (f_valid && exp_rdy && !exp_byp) begin
          mq.push_back('{pc: f_pc, instr: f_instr, lf: f_lf, pf: f_pf});
          fault_seen = f_lf | f_pf;
        end
        if (exp_byp) fault_seen = f_lf | f_pf;
        if (fault_seen) mlock = 1;
      end
    end

    // asynchronous reset while holding data takes effect without a clock edge
    do_reset();
    @(negedge clk); f_valid = 1; f_pc = 64'h6000; f_instr = instr_of(64'h6000);
    @(negedge clk); f_pc = 64'h6004;
    @(negedge clk); idle_inputs(); #1;
    chk("pre_arst_count", o_count, 2);
    rst = 1'b1;
    #1;
    chk("arst_count",   o_count,   0);
    chk("arst_empty",   o_empty,   1);
    chk("arst_d_valid", o_d_valid, 0);
    chk("arst_d_pc",    o_d_pc,    0);
    #2;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
